axi_sram_bist: RTL and testbench

AXI_SRAM_BIST -- requirements
Module: axi_sram_bist

---
 rtl/axi_sram_bist_if.sv | 65 ++++++
 rtl/axi_sram_bist.sv | 188 ++++++++++++++++++
 tb/tb_axi_sram_bist.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_bist_if.sv
// AXI4 manager/subordinate bundle with 64-bit data, as seen by the SRAM BIST.
interface axi_sram_bist_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [63:0]           wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [63:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_sram_bist.sv
// SRAM BIST over AXI: writes an address-derived pattern in 16-beat bursts,
// reads it back and counts response/data errors.
module axi_sram_bist #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [11:0]           num_bursts_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  axi_sram_bist_if.master       axi
);
  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
  logic [11:0]           nb_q, nb_d, burst_q, burst_d;
  logic [3:0]            beat_q, beat_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  pass_q, pass_d, done_q, done_d;

  logic [ADDR_WIDTH-1:0] burst_addr, beat_addr, err_addr;
  logic                  last_burst, err_hit;

  function automatic logic [63:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return {~a32, a32};
  endfunction

  // Base is 128-byte aligned and bursts are 128 bytes, so no burst crosses 4 KB.
  assign burst_addr = base_q + ADDR_WIDTH'({burst_q, 7'b0});
  assign beat_addr  = burst_addr + ADDR_WIDTH'({beat_q, 3'b0});
  assign last_burst = (burst_q == nb_q - 12'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      base_q           <= '0;
      first_err_addr_q <= '0;
      nb_q             <= '0;
      burst_q          <= '0;
      beat_q           <= '0;
      err_count_q      <= '0;
      pass_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      first_err_addr_q <= first_err_addr_d;
      nb_q             <= nb_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      err_count_q      <= err_count_d;
      pass_q           <= pass_d;
      done_q           <= done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    first_err_addr_d = first_err_addr_q;
    nb_d             = nb_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    err_count_d      = err_count_q;
    pass_d           = pass_q;
    done_d           = 1'b0;
    err_hit          = 1'b0;
    err_addr         = burst_addr;
    case (state_q)
      IDLE: if (start_i) begin
        base_d           = base_addr_i & ~ADDR_WIDTH'(7'h7F);
        nb_d             = num_bursts_i;
        burst_d          = '0;
        beat_d           = '0;
        err_count_d      = '0;
        first_err_addr_d = '0;
        pass_d           = 1'b0;
        state_d          = (num_bursts_i == 12'd0) ? DONE : WR_AW;
      end
      WR_AW: if (axi.awready) state_d = WR_W;
      WR_W: if (axi.wready) begin
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'd15) state_d = WR_B;
      end
      WR_B: if (axi.bvalid) begin
        err_hit = (axi.bresp != 2'b00);
        if (last_burst) begin
          burst_d = '0;
          state_d = RD_AR;
        end else begin
          burst_d = burst_q + 12'd1;
          state_d = WR_AW;
        end
      end
      RD_AR: if (axi.arready) state_d = RD_R;
      RD_R: if (axi.rvalid) begin
        // Response, data and rlast-position faults on one beat count once.
        err_hit  = (axi.rresp != 2'b00) || (axi.rdata != pattern(beat_addr)) ||
                   (axi.rlast != (beat_q == 4'd15));
        err_addr = beat_addr;
        beat_d   = beat_q + 4'd1;
        if (axi.rlast) begin
          beat_d = '0;
          if (last_burst) begin
            state_d = DONE;
          end else begin
            burst_d = burst_q + 12'd1;
            state_d = RD_AR;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == 16'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (err_hit) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (err_count_q == 16'd0) first_err_addr_d = err_addr;
    end
  end

  // Payloads are zero whenever the matching valid is low, so they stay stable
  // while valid is held and read as zero out of reset.
  always_comb begin
    axi.awid    = '0;
    axi.awaddr  = '0;
    axi.awlen   = '0;
    axi.awsize  = '0;
    axi.awburst = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arid    = '0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    case (state_q)
      WR_AW: begin
        axi.awvalid = 1'b1;
        axi.awaddr  = burst_addr;
        axi.awlen   = 8'd15;
        axi.awsize  = 3'd3;
        axi.awburst = 2'b01;
      end
      WR_W: begin
        axi.wvalid = 1'b1;
        axi.wdata  = pattern(beat_addr);
        axi.wstrb  = 8'hFF;
        axi.wlast  = (beat_q == 4'd15);
      end
      WR_B: axi.bready = 1'b1;
      RD_AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = burst_addr;
        axi.arlen   = 8'd15;
        axi.arsize  = 3'd3;
        axi.arburst = 2'b01;
      end
      RD_R: axi.rready = 1'b1;
      default: ;
    endcase
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;
endmodule

// File: tb/tb_axi_sram_bist.sv
// Directed bench for axi_sram_bist with a memory-backed AXI subordinate model.
module tb_axi_sram_bist;
  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [31:0] base_addr_i;
  logic [11:0] num_bursts_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;

  axi_sram_bist_if #(.ID_WIDTH(1), .ADDR_WIDTH(32)) axi ();

  axi_sram_bist #(.ID_WIDTH(1), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_bursts_i(num_bursts_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o), .axi(axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Subordinate model state, owned by the negedge process below.
  logic [63:0] mem [logic [31:0]];
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wbeat, rbeat;
  logic [31:0] exp_base, wa, ra, aw_hold_addr, ar_hold_addr, corrupt_addr;
  logic [64:0] w_hold;
  bit          b_pend, r_act, any_valid, aw_wait, w_wait, ar_wait;
  bit          stall_en, corrupt_en;
  int          slverr_burst;

  initial begin
    {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
    {axi.bid, axi.bresp, axi.rid, axi.rdata, axi.rresp, axi.rlast} = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
        {b_pend, r_act, aw_wait, w_wait, ar_wait} = '0;
        continue;
      end
      if (start_i && !busy_o) begin
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        any_valid = 1'b0;
        exp_base  = base_addr_i & ~32'h7F;
      end
      if (axi.awvalid || axi.wvalid || axi.arvalid) any_valid = 1'b1;
      if (aw_wait) chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, aw_hold_addr});
      if (w_wait)  chk("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, w_hold});
      if (ar_wait) chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, ar_hold_addr});
      // Responses for this cycle
      axi.bvalid = b_pend;
      axi.bresp  = (b_pend && b_cnt == slverr_burst) ? 2'b10 : 2'b00;
      axi.rvalid = r_act;
      axi.rlast  = r_act && (rbeat == 15);
      axi.rdata  = (r_act && mem.exists(ra)) ? mem[ra] : 64'h0;
      axi.rresp  = 2'b00;
      if (r_act && corrupt_en && ra == corrupt_addr) begin
        axi.rdata = axi.rdata ^ 64'h1;
        axi.rresp = 2'b10;
      end
      axi.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      // Handshakes that the coming rising edge will complete
      aw_wait = axi.awvalid && !axi.awready;  aw_hold_addr = axi.awaddr;
      w_wait  = axi.wvalid && !axi.wready;    w_hold = {axi.wlast, axi.wdata};
      ar_wait = axi.arvalid && !axi.arready;  ar_hold_addr = axi.araddr;
      if (axi.awvalid && axi.awready) begin
        chk("awaddr", axi.awaddr, exp_base + 32'(128 * aw_cnt));
        chk("aw_attr", {axi.awid, axi.awlen, axi.awsize, axi.awburst}, {1'b0, 8'd15, 3'd3, 2'b01});
        aw_cnt++; wa = axi.awaddr; wbeat = 0;
      end
      if (axi.wvalid && axi.wready) begin
        chk("w_beat", {axi.wstrb, axi.wlast, axi.wdata}, {8'hFF, wbeat == 15, ~wa, wa});
        mem[wa] = axi.wdata; wa += 8; wbeat++; w_cnt++;
        if (wbeat == 16) b_pend = 1'b1;
      end
      if (axi.bvalid && axi.bready) begin b_pend = 1'b0; b_cnt++; end
      if (axi.rvalid && axi.rready) begin
        ra += 8; rbeat++; r_cnt++;
        if (rbeat == 16) r_act = 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        chk("araddr", axi.araddr, exp_base + 32'(128 * ar_cnt));
        chk("ar_attr", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {1'b0, 8'd15, 3'd3, 2'b01});
        ar_cnt++; ra = axi.araddr; rbeat = 0; r_act = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy_o, done_o, pass_o, err_count_o, first_err_addr_o, axi.awvalid,
                        axi.wvalid, axi.arvalid, axi.bready, axi.rready}, '0);
    chk({tag, "_addr"}, {axi.awaddr, axi.awlen, axi.awsize, axi.awburst,
                         axi.araddr, axi.arlen, axi.arsize, axi.arburst}, '0);
    chk({tag, "_wdata"}, {axi.wdata, axi.wstrb, axi.wlast}, '0);
  endtask

  task automatic launch(input logic [31:0] b, input logic [11:0] n);
    start_i = 1'b1; base_addr_i = b; num_bursts_i = n;
    step();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1'b1);
    chk("start_awvalid", axi.awvalid, n != 12'd0);
    chk("start_clears", {pass_o, err_count_o, first_err_addr_o}, '0);
  endtask

  task automatic run_test(input string tag, input logic [31:0] b, input logic [11:0] n,
                          input logic exp_pass, input logic [15:0] exp_err,
                          input logic [31:0] exp_first);
    int cyc = 0;
    launch(b, n);
    while (done_o !== 1'b1 && cyc < 3000) begin
      // A start request in mid-test must be ignored
      if (cyc == 4) begin start_i = 1'b1; base_addr_i = 32'h5000; num_bursts_i = 12'd0; end
      else if (cyc == 5) begin start_i = 1'b0; base_addr_i = b; num_bursts_i = n; end
      step(); cyc++;
    end
    chk({tag, "_done"}, {done_o, busy_o}, 2'b10);
    chk({tag, "_result"}, {pass_o, err_count_o, first_err_addr_o}, {exp_pass, exp_err, exp_first});
    chk({tag, "_counts"}, {16'(aw_cnt), 16'(w_cnt), 16'(ar_cnt), 16'(r_cnt)},
        {{4'b0, n}, {n, 4'b0}, {4'b0, n}, {n, 4'b0}});
    step();
    chk({tag, "_pulse"}, {done_o, pass_o}, {1'b0, exp_pass});
  endtask

  initial begin
    logic [48:0] ideal_res;
    int cyc;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_bursts_i = '0;
    stall_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0; slverr_burst = -1;
    repeat (3) step();
    check_reset_outs("por");
    rst_i = 1'b0;
    step();

    run_test("ideal", 32'h1000, 12'd2, 1'b1, 16'd0, 32'h0);
    ideal_res = {pass_o, err_count_o, first_err_addr_o};

    corrupt_en = 1'b1; corrupt_addr = 32'h1088;
    run_test("corrupt", 32'h1000, 12'd2, 1'b0, 16'd1, 32'h1088);
    corrupt_en = 1'b0;

    // Zero bursts: done two cycles after start, nothing on the bus
    launch(32'h1000, 12'd0);
    chk("zero_c1", {done_o, busy_o}, 2'b01);
    step();
    chk("zero_c2", {done_o, busy_o, pass_o, err_count_o}, {3'b101, 16'd0});
    chk("zero_no_valid", any_valid, 1'b0);
    step();

    stall_en = 1'b1;
    run_test("stall", 32'h1000, 12'd2, 1'b1, 16'd0, 32'h0);
    chk("stall_vs_ideal", {pass_o, err_count_o, first_err_addr_o}, ideal_res);
    stall_en = 1'b0;

    slverr_burst = 1;
    run_test("slverr", 32'h0, 12'd2, 1'b0, 16'd1, 32'h80);
    slverr_burst = -1;

    // Unaligned base is treated as aligned
    run_test("unaligned", 32'h4057, 12'd3, 1'b1, 16'd0, 32'h0);

    // Reset while the eighth write beat is on the bus
    launch(32'h2000, 12'd2);
    cyc = 0;
    while (!(w_cnt == 7 && axi.wvalid) && cyc < 500) begin step(); cyc++; end
    chk("beat7_reached", {axi.wvalid, 16'(w_cnt)}, {1'b1, 16'd7});
    rst_i = 1'b1;
    step();
    check_reset_outs("mid_rst");
    rst_i = 1'b0;
    step();
    run_test("after_rst", 32'h3000, 12'd1, 1'b1, 16'd0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
